leve1_id: RTL and testbench
===========================

LEVE1_ID -- requirements
Module: leve1_id

Interface
REQ-001 SHALL have ports: CLK in 1 (clock); RST in 1 (asynchronous active-high reset); all state rises on CLK.
REQ-002 SHALL have IF side: IF_VALID in 1; IF_PC in XLEN; IF_INSTR in 32; IF_READY out 1.
REQ-003 SHALL have FLUSH in 1, driven from the execute stage's OFLASH.
REQ-004 SHALL have execute-side outputs: OVALID out 1; OPC out XLEN; OINSTR out 32; ORS1 out XLEN; ORS2 out XLEN; OCSR out XLEN.
REQ-005 SHALL have writeback inputs: WB_VALID in 1; WB_INSTR in 32; WB_WE in 1; WB_RD in XLEN; WB_CSRD in XLEN.
REQ-006 SHALL have OMEPC out XLEN and OMTVEC out XLEN, both direct register contents.

Function
REQ-007 SHALL drive IF_READY = 1 whenever RST is low.
REQ-008 SHALL hold one instruction register (valid, pc, instr), loaded every cycle: OVALID <= IF_VALID && !FLUSH; OPC <= IF_PC; OINSTR <= IF_INSTR. Latency is 1 cycle.
REQ-009 SHALL drop the instruction accepted in a FLUSH cycle, so OVALID = 0 on the next cycle.
REQ-010 SHALL keep a 32 x XLEN integer register file; x0 reads 0 and ignores writes.
REQ-011 SHALL write x[WB_INSTR[11:7]] <= WB_RD at the clock edge when WB_VALID && WB_WE.
REQ-012 SHALL drive ORS1/ORS2 combinationally from OINSTR[19:15]/[24:20], with write-through: a same-cycle matching nonzero write returns WB_RD.
REQ-013 SHALL implement these CSRs:
- mstatus 0x300, read/write; bits [33:32] and [35:34] read as 2'b10.
- misa 0x301, read-only constant: RV64I+M.
- mtvec 0x305, read/write.
- mscratch 0x340, read/write.
- mepc 0x341, read/write; bits [1:0] read as 0.
- mcause 0x342, read/write.
- mhartid 0xF14, reads 0.
- Any other address reads 0 and ignores writes.
REQ-014 SHALL drive OCSR combinationally from the CSR addressed by OINSTR[31:20].
REQ-015 OCSR SHALL give the same-cycle writeback result (write-through) when a CSR write targets the same address.
REQ-016 SHALL perform a CSR write when WB_VALID and WB_INSTR opcode = SYSTEM and funct3 is nonzero, with cmd = funct3[1:0] and csr = current value:
- cmd 01 (RW): csr <= WB_CSRD.
- cmd 10 (RS): csr <= csr | WB_CSRD.
- cmd 11 (RC): csr <= csr & ~WB_CSRD.
REQ-017 SHALL suppress RS/RC writes when WB_INSTR[19:15] = 0.
REQ-018 SHALL write mstatus <= WB_CSRD when WB_VALID and WB_INSTR is MRET (funct3 000, funct7 0011000, rs2 00010), regardless of the address field.
REQ-019 SHALL ignore WB_WE and all CSR effects when WB_VALID = 0.

Reset
REQ-020 While RST is high: OVALID = 0, IF_READY = 0, OPC = 0, OINSTR = 0 (NOP not required).
REQ-021 While RST is high: all integer registers = 0; mstatus, mtvec, mscratch, mepc and mcause = 0.
REQ-022 SHALL apply reset asynchronously on RST rise, including mid-write; writes in that cycle are lost.
REQ-023 SHALL make the first capture the first CLK edge with RST low.

Structure
REQ-024 SHALL place XLEN, the CSR addresses, the CSR_NONE/WRITE/SET/CLEAR command codes, the opcode constants and the MISA value in the shared defs package.
REQ-025 SHALL use one sub-module, leve1_regfile (2 read ports, 1 write port, write-through, x0 zero); the CSR file stays inline.

Verification
REQ-026 Reset: assert RST mid-stream with x5 = 7 -> OVALID = 0, IF_READY = 0; after release, ORS1 for rs1 = x5 reads 0.
REQ-027 Write-through: WB writes x3 = 0x1234 while OINSTR has rs1 = x3 -> ORS1 = 0x1234 in the same cycle; x0 write of 0x55 -> x0 still reads 0.
REQ-028 CSR ops, starting from mscratch = 0xF0:
- CSRRS with data 0x0F -> mscratch = 0xFF.
- Then CSRRC with data 0x3 -> 0xFC.
- CSRRS with rs1 = x0 -> mscratch unchanged.
REQ-029 Flush: IF_VALID = 1 with FLUSH = 1 -> next cycle OVALID = 0; the cycle after, a normal instruction gives OVALID = 1 with OPC = IF_PC.
REQ-030 MRET in writeback with WB_CSRD = 0x1880 -> mstatus reads 0x0000000A_00001880; mepc write 0x1003 reads 0x1000.

Source files
------------

// File: rtl/leve1_id_pkg.sv
// leve1_id_pkg: shared widths, CSR map, command codes and the CSR read view.
package leve1_id_pkg;
    localparam int XLEN = 64;
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
    localparam logic [6:0] FUNCT7_MRET = 7'b0011000;
    localparam logic [4:0] RS2_MRET    = 5'b00010;
    // MXL=2 (RV64), extensions I and M
    localparam logic [XLEN-1:0] MISA = 64'h8000_0000_0000_1100;
    typedef enum logic [1:0] {
        CSR_NONE  = 2'b00,
        CSR_WRITE = 2'b01,
        CSR_SET   = 2'b10,
        CSR_CLEAR = 2'b11
    } csr_cmd_e;
    typedef struct packed {
        logic [XLEN-1:0] mstatus;
        logic [XLEN-1:0] mtvec;
        logic [XLEN-1:0] mscratch;
        logic [XLEN-1:0] mepc;
        logic [XLEN-1:0] mcause;
    } csr_regs_t;
    // mstatus UXL/SXL are hardwired to RV64; mhartid and unmapped addresses read 0
    function automatic logic [XLEN-1:0] csr_view(input logic [11:0] addr, input csr_regs_t r);
        return addr == CSR_MSTATUS  ? {r.mstatus[XLEN-1:36], 4'b1010, r.mstatus[31:0]} :
               addr == CSR_MISA     ? MISA :
               addr == CSR_MTVEC    ? r.mtvec :
               addr == CSR_MSCRATCH ? r.mscratch :
               addr == CSR_MEPC     ? {r.mepc[XLEN-1:2], 2'b00} :
               addr == CSR_MCAUSE   ? r.mcause :
               addr == CSR_MHARTID  ? '0 : '0;
    endfunction
endpackage

// File: rtl/leve1_id_regfile.sv
// leve1_id_regfile: 32 x XLEN integer registers, 2 read / 1 write, write-through, x0 hardwired 0.
module leve1_id_regfile
    import leve1_id_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);
    logic [XLEN-1:0] regs_q [32];
    logic [XLEN-1:0] regs_d [32];
    always_comb begin
        regs_d = regs_q;
        if (we && waddr != 5'd0) regs_d[waddr] = wdata;
        regs_d[0] = '0;
    end
    // reading the next-state array gives same-cycle write-through
    assign rdata1 = regs_d[raddr1];
    assign rdata2 = regs_d[raddr2];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) regs_q <= '{default: '0};
        else     regs_q <= regs_d;
    end
endmodule

// File: rtl/leve1_id.sv
// leve1_id: decode stage holding the instruction register, integer regfile and machine CSRs.
module leve1_id
    import leve1_id_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    input  logic            IF_VALID,
    input  logic [XLEN-1:0] IF_PC,
    input  logic [31:0]     IF_INSTR,
    output logic            IF_READY,
    input  logic            FLUSH,
    output logic            OVALID,
    output logic [XLEN-1:0] OPC,
    output logic [31:0]     OINSTR,
    output logic [XLEN-1:0] ORS1,
    output logic [XLEN-1:0] ORS2,
    output logic [XLEN-1:0] OCSR,
    input  logic            WB_VALID,
    input  logic [31:0]     WB_INSTR,
    input  logic            WB_WE,
    input  logic [XLEN-1:0] WB_RD,
    input  logic [XLEN-1:0] WB_CSRD,
    output logic [XLEN-1:0] OMEPC,
    output logic [XLEN-1:0] OMTVEC
);
    logic            ovalid_q, ovalid_d;
    logic [XLEN-1:0] opc_q, opc_d;
    logic [31:0]     oinstr_q, oinstr_d;
    csr_regs_t       csr_q, csr_d;
    csr_cmd_e        cmd;
    logic            wb_sys, csr_wen, mret;
    logic [11:0]     wb_addr;
    logic [XLEN-1:0] csr_cur, csr_new;
    always_comb begin
        ovalid_d = IF_VALID && !FLUSH;
        opc_d    = IF_PC;
        oinstr_d = IF_INSTR;
        wb_sys   = WB_VALID && WB_INSTR[6:0] == OPC_SYSTEM;
        cmd      = csr_cmd_e'(WB_INSTR[13:12]);
        wb_addr  = WB_INSTR[31:20];
        // set/clear with rs1 = x0 is a pure read
        csr_wen  = wb_sys && cmd != CSR_NONE && (cmd == CSR_WRITE || WB_INSTR[19:15] != 5'd0);
        mret     = wb_sys && WB_INSTR[14:12] == 3'b000 && WB_INSTR[31:25] == FUNCT7_MRET
                   && WB_INSTR[24:20] == RS2_MRET;
        csr_cur  = csr_view(wb_addr, csr_q);
        csr_new  = cmd == CSR_WRITE ? WB_CSRD :
                   cmd == CSR_SET   ? csr_cur | WB_CSRD : csr_cur & ~WB_CSRD;
        csr_d.mstatus  = mret ? WB_CSRD :
                         (csr_wen && wb_addr == CSR_MSTATUS) ? csr_new : csr_q.mstatus;
        csr_d.mtvec    = (csr_wen && wb_addr == CSR_MTVEC)    ? csr_new : csr_q.mtvec;
        csr_d.mscratch = (csr_wen && wb_addr == CSR_MSCRATCH) ? csr_new : csr_q.mscratch;
        csr_d.mepc     = ((csr_wen && wb_addr == CSR_MEPC) ? csr_new : csr_q.mepc) & ~XLEN'(3);
        csr_d.mcause   = (csr_wen && wb_addr == CSR_MCAUSE)   ? csr_new : csr_q.mcause;
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovalid_q <= 1'b0;
            opc_q    <= '0;
            oinstr_q <= '0;
            csr_q    <= '0;
        end else begin
            ovalid_q <= ovalid_d;
            opc_q    <= opc_d;
            oinstr_q <= oinstr_d;
            csr_q    <= csr_d;
        end
    end
    leve1_id_regfile u_regfile (
        .clk    (CLK),
        .rst    (RST),
        .we     (WB_VALID && WB_WE),
        .waddr  (WB_INSTR[11:7]),
        .wdata  (WB_RD),
        .raddr1 (oinstr_q[19:15]),
        .raddr2 (oinstr_q[24:20]),
        .rdata1 (ORS1),
        .rdata2 (ORS2)
    );
    assign IF_READY = !RST;
    assign OVALID   = ovalid_q;
    assign OPC      = opc_q;
    assign OINSTR   = oinstr_q;
    assign OCSR     = csr_view(oinstr_q[31:20], csr_d);
    assign OMEPC    = csr_q.mepc;
    assign OMTVEC   = csr_q.mtvec;
endmodule

// File: tb/tb_leve1_id.sv
// tb_leve1_id: table-driven CSR vectors, hand-written corner sequences and random traffic vs a reference model.
module tb_leve1_id;
    logic        CLK = 1'b0, RST = 1'b1;
    logic        IF_VALID = 1'b0, FLUSH = 1'b0, WB_VALID = 1'b0, WB_WE = 1'b0;
    logic [63:0] IF_PC = '0, WB_RD = '0, WB_CSRD = '0;
    logic [31:0] IF_INSTR = '0, WB_INSTR = '0;
    logic        IF_READY, OVALID;
    logic [63:0] OPC, ORS1, ORS2, OCSR, OMEPC, OMTVEC;
    logic [31:0] OINSTR;
    leve1_id dut (
        .CLK(CLK), .RST(RST), .IF_VALID(IF_VALID), .IF_PC(IF_PC), .IF_INSTR(IF_INSTR),
        .IF_READY(IF_READY), .FLUSH(FLUSH), .OVALID(OVALID), .OPC(OPC), .OINSTR(OINSTR),
        .ORS1(ORS1), .ORS2(ORS2), .OCSR(OCSR), .WB_VALID(WB_VALID), .WB_INSTR(WB_INSTR),
        .WB_WE(WB_WE), .WB_RD(WB_RD), .WB_CSRD(WB_CSRD), .OMEPC(OMEPC), .OMTVEC(OMTVEC)
    );
    always #5 CLK = ~CLK;

    localparam logic [63:0] MISA_EXP = 64'h8000_0000_0000_1100;
    int          total = 0, bad = 0;
    logic [63:0] xm [32];
    logic [63:0] csr_m [int];
    logic        exp_valid, nxt_valid;
    logic [63:0] exp_pc, nxt_pc;
    logic [31:0] exp_instr, nxt_instr;
    logic [11:0] al [8] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'hF14, 12'h7C0};

    typedef struct {
        logic        wv;
        logic [31:0] wi;
        logic [63:0] d;
        logic [11:0] ra;
        logic [63:0] exp;
    } csr_vec_t;
    csr_vec_t tbl [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] csr_ins(input logic [11:0] a, input logic [4:0] rs1, input logic [2:0] f3);
        return {a, rs1, f3, 5'd1, 7'h73};
    endfunction

    function automatic logic [63:0] csr_rd(input logic [11:0] a);
        logic [63:0] v;
        if (a == 12'h301) return MISA_EXP;
        if (!csr_m.exists(int'(a))) return 64'h0;
        v = csr_m[int'(a)];
        if (a == 12'h300) v[35:32] = 4'hA;
        if (a == 12'h341) v[1:0] = 2'b00;
        return v;
    endfunction

    task automatic csr_wr(input logic [11:0] a, input logic [63:0] v);
        if (csr_m.exists(int'(a))) csr_m[int'(a)] = (a == 12'h341) ? (v & ~64'h3) : v;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) xm[i] = 64'h0;
        csr_m.delete();
        csr_m['h300] = 0; csr_m['h305] = 0; csr_m['h340] = 0; csr_m['h341] = 0; csr_m['h342] = 0;
        exp_valid = 0; exp_pc = 0; exp_instr = 0;
        nxt_valid = 0; nxt_pc = 0; nxt_instr = 0;
    endtask

    task automatic model_wb(input logic wv, input logic [31:0] wi, input logic we,
                            input logic [63:0] wrd, input logic [63:0] wcsrd);
        logic [63:0] cur;
        if (!wv) return;
        if (we && wi[11:7] != 5'd0) xm[wi[11:7]] = wrd;
        if (wi[6:0] != 7'h73) return;
        if (wi[14:12] == 3'b000 && wi[31:25] == 7'b0011000 && wi[24:20] == 5'd2)
            csr_wr(12'h300, wcsrd);
        else if (wi[13:12] != 2'b00 && (wi[13:12] == 2'b01 || wi[19:15] != 5'd0)) begin
            cur = csr_rd(wi[31:20]);
            csr_wr(wi[31:20], wi[13:12] == 2'b01 ? wcsrd : wi[13:12] == 2'b10 ? (cur | wcsrd) : (cur & ~wcsrd));
        end
    endtask

    task automatic drive(input logic iv, input logic [63:0] ipc, input logic [31:0] ii, input logic fl,
                         input logic wv, input logic [31:0] wi, input logic we,
                         input logic [63:0] wrd, input logic [63:0] wcsrd);
        @(negedge CLK);
        check("ovalid", OVALID, exp_valid);
        check("opc", OPC, exp_pc);
        check("oinstr", OINSTR, exp_instr);
        check("if_ready", IF_READY, 1);
        check("omepc", OMEPC, csr_m['h341]);
        check("omtvec", OMTVEC, csr_m['h305]);
        IF_VALID = iv; IF_PC = ipc; IF_INSTR = ii; FLUSH = fl;
        WB_VALID = wv; WB_INSTR = wi; WB_WE = we; WB_RD = wrd; WB_CSRD = wcsrd;
        model_wb(wv, wi, we, wrd, wcsrd);
        #2;
        check("ors1", ORS1, xm[exp_instr[19:15]]);
        check("ors2", ORS2, xm[exp_instr[24:20]]);
        check("ocsr", OCSR, csr_rd(exp_instr[31:20]));
        nxt_valid = iv && !fl; nxt_pc = ipc; nxt_instr = ii;
    endtask

    task automatic tick();
        @(posedge CLK);
        exp_valid = nxt_valid; exp_pc = nxt_pc; exp_instr = nxt_instr;
        #1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, csr_ins(12'h340, 5'd1, 3'b001), 64'hF0,   12'h340, 64'hF0};
        tbl[1]  = '{1'b1, csr_ins(12'h340, 5'd1, 3'b010), 64'h0F,   12'h340, 64'hFF};
        tbl[2]  = '{1'b1, csr_ins(12'h340, 5'd1, 3'b011), 64'h3,    12'h340, 64'hFC};
        tbl[3]  = '{1'b1, csr_ins(12'h340, 5'd0, 3'b010), 64'hFF,   12'h340, 64'hFC};
        tbl[4]  = '{1'b1, csr_ins(12'h341, 5'd1, 3'b001), 64'h1003, 12'h341, 64'h1000};
        tbl[5]  = '{1'b1, 32'h30200073,                   64'h1880, 12'h300, 64'h0000000A_00001880};
        tbl[6]  = '{1'b1, csr_ins(12'h300, 5'd1, 3'b011), 64'h80,   12'h300, 64'h0000000A_00001800};
        tbl[7]  = '{1'b1, csr_ins(12'h301, 5'd1, 3'b001), 64'h0,    12'h301, MISA_EXP};
        tbl[8]  = '{1'b1, csr_ins(12'hF14, 5'd1, 3'b001), 64'h7,    12'hF14, 64'h0};
        tbl[9]  = '{1'b1, csr_ins(12'h7C0, 5'd1, 3'b001), 64'h5,    12'h7C0, 64'h0};
        tbl[10] = '{1'b1, csr_ins(12'h305, 5'd9, 3'b101), 64'hABC,  12'h305, 64'hABC};
        tbl[11] = '{1'b1, csr_ins(12'h305, 5'd0, 3'b111), 64'hFFF,  12'h305, 64'hABC};
        tbl[12] = '{1'b0, csr_ins(12'h342, 5'd1, 3'b001), 64'h77,   12'h342, 64'h0};
        model_reset();
        #3;
        check("init_if_ready", IF_READY, 0);
        check("init_ovalid", OVALID, 0);
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(1, 64'h1000 + 64'(i), {tbl[i].ra, 20'h0}, 0, 0, 0, 0, 0, 0);
            tick();
            drive(1, 64'h2000 + 64'(i), {tbl[i].ra, 20'h0}, 0, tbl[i].wv, tbl[i].wi, 0, 0, tbl[i].d);
            check("csr_wt", OCSR, tbl[i].exp);
            tick();
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            check("csr_hold", OCSR, tbl[i].exp);
            tick();
        end

        drive(1, 64'h200, {12'h0, 5'd3, 3'b000, 5'd0, 7'h13}, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, {20'h0, 5'd3, 7'h33}, 1, 64'h1234, 0);
        check("wt_x3", ORS1, 64'h1234);
        tick();
        drive(1, 64'h204, 32'h13, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, {20'h0, 5'd0, 7'h33}, 1, 64'h55, 0);
        check("x0_wt", ORS1, 64'h0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("x0_hold", ORS1, 64'h0);
        tick();

        drive(1, 64'h100, 32'h13, 1, 0, 0, 0, 0, 0);
        tick();
        check("flush_ovalid", OVALID, 0);
        drive(1, 64'h104, 32'h13, 0, 0, 0, 0, 0, 0);
        tick();
        check("post_flush_ovalid", OVALID, 1);
        check("post_flush_opc", OPC, 64'h104);

        drive(1, 64'h40, {12'h0, 5'd5, 3'b000, 5'd0, 7'h13}, 0, 1, {20'h0, 5'd5, 7'h33}, 1, 64'h7, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("x5_pre", ORS1, 64'h7);
        WB_VALID = 1; WB_WE = 1; WB_INSTR = {20'h0, 5'd5, 7'h33}; WB_RD = 64'h9;
        IF_VALID = 1; IF_PC = 64'h77; IF_INSTR = 32'hDEAD_BEEF;
        #1 RST = 1'b1;
        #1;
        check("rst_ovalid", OVALID, 0);
        check("rst_if_ready", IF_READY, 0);
        check("rst_opc", OPC, 0);
        check("rst_oinstr", OINSTR, 0);
        model_reset();
        @(posedge CLK); #1;
        check("rst_hold_ovalid", OVALID, 0);
        check("rst_omepc", OMEPC, 0);
        @(negedge CLK);
        RST = 1'b0;
        WB_VALID = 0; WB_WE = 0; WB_INSTR = 0; WB_RD = 0;
        IF_VALID = 1; IF_PC = 64'h300; IF_INSTR = {12'h0, 5'd5, 3'b000, 5'd0, 7'h13};
        @(posedge CLK); #1;
        exp_valid = 1; exp_pc = 64'h300; exp_instr = {12'h0, 5'd5, 3'b000, 5'd0, 7'h13};
        check("first_capture_ovalid", OVALID, 1);
        check("first_capture_opc", OPC, 64'h300);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("x5_after_rst", ORS1, 64'h0);
        check("mscratch_after_rst", csr_rd(12'h340), 64'h0);
        tick();

        for (int n = 0; n < 400; n++) begin
            logic [31:0] wi;
            int          mode;
            mode = int'($urandom_range(0, 3));
            wi = mode == 0 ? $urandom :
                 mode == 1 ? csr_ins(al[$urandom_range(0, 7)], ($urandom % 3 == 0) ? 5'd0 : 5'($urandom), 3'($urandom)) :
                 mode == 2 ? 32'h30200073 : {$urandom_range(0, 20'hFFFFF), 5'($urandom), 7'h33};
            drive(1'($urandom), {$urandom, $urandom}, {al[$urandom_range(0, 7)], 20'($urandom)},
                  $urandom % 5 == 0, 1'($urandom), wi, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
